// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller sitting in front of the 8-bit ALU.
// It accepts one 16-bit instruction per handshake and owns a 16x8 register file.
// ALU-class instructions drive the operand and control pins, then write the
// result taken from the shared bus back to rd. Branch instructions sample
// check_branch and request a PC-relative load from fetch.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr             instruction word
//   instr_valid       producer handshake: instr is valid
//   instr_ready       sequencer handshake: can accept (state IDLE)
//   alu_value1        ALU operand 1 (held between uses)
//   alu_value2        ALU operand 2 (held between uses)
//   alu_operator      ALU operator (held between uses)
//   alu_single        ALU single-operand select (held between uses)
//   alu_cs_in         ALU compute strobe (EXEC)
//   alu_cs_out        ALU result-drive enable (WB)
//   alu_bus           shared result bus
//   alu_check_branch  branch condition from the ALU
//   pc_load           one-cycle pulse: fetch adds pc_offset to PC
//   pc_offset         sign-extended branch offset (held)
//   done              one-cycle pulse: instruction retired
//   dbg_addr          debug register select
//   dbg_data          rf[dbg_addr], combinational
module alu_sequencer #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned PCW    = 16,
    parameter logic [3:0]  OP_CMP = 4'h7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    output logic [7:0]     alu_value1,
    output logic [7:0]     alu_value2,
    output logic [3:0]     alu_operator,
    output logic           alu_single,
    output logic           alu_cs_in,
    output logic           alu_cs_out,
    input  logic [7:0]     alu_bus,
    input  logic           alu_check_branch,
    output logic           pc_load,
    output logic [PCW-1:0] pc_offset,
    output logic           done,
    input  logic [3:0]     dbg_addr,
    output logic [7:0]     dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WB,
        BR,
        RET
    } state_t;

    localparam logic [1:0] CLS_ALU2 = 2'b00;
    localparam logic [1:0] CLS_ALU1 = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;
    localparam logic [1:0] CLS_LI   = 2'b11;

    state_t     state;
    state_t     state_next;
    logic       accept;

    logic [7:0] rf [NREGS];

    // Latched instruction fields; ir_lo carries {rd, rs} or the branch offset.
    logic [1:0] ir_cls;
    logic [3:0] ir_op;
    logic [7:0] ir_lo;
    logic       pc_load_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobe outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        alu_cs_in   = 1'b0;
        alu_cs_out  = 1'b0;
        pc_load     = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept = 1'b1;
                    unique case (instr[15:14])
                        CLS_ALU2, CLS_ALU1: state_next = EXEC;
                        CLS_BR:             state_next = BR;
                        CLS_LI:             state_next = RET;
                        default:            state_next = IDLE;
                    endcase
                end
            end
            EXEC: begin
                alu_cs_in  = 1'b1;
                state_next = WB;
            end
            WB: begin
                alu_cs_out = 1'b1;
                state_next = RET;
            end
            BR: begin
                state_next = RET;
            end
            RET: begin
                done       = 1'b1;
                pc_load    = pc_load_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: instruction register, register file, held ALU pins
    // ------------------------------------------------------------------
    // Operands are loaded at the accept edge so they are already stable on the
    // pins during EXEC; no rf write can occur between accept and EXEC for an
    // ALU-class instruction, so this equals reading rf during EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf           <= '{default: '0};
            ir_cls       <= '0;
            ir_op        <= '0;
            ir_lo        <= '0;
            pc_load_reg  <= 1'b0;
            alu_value1   <= '0;
            alu_value2   <= '0;
            alu_operator <= '0;
            alu_single   <= 1'b0;
            pc_offset    <= '0;
        end else begin
            if (accept) begin
                ir_cls      <= instr[15:14];
                ir_op       <= instr[13:10];
                ir_lo       <= instr[7:0];
                // Cleared so a stale branch result never pulses pc_load in RET.
                pc_load_reg <= 1'b0;
                unique case (instr[15:14])
                    CLS_ALU2: begin
                        alu_value1   <= rf[instr[7:4]];
                        alu_value2   <= rf[instr[3:0]];
                        alu_operator <= instr[13:10];
                        alu_single   <= 1'b0;
                    end
                    CLS_ALU1: begin
                        alu_value1   <= rf[instr[7:4]];
                        alu_value2   <= '0;
                        alu_operator <= instr[13:10];
                        alu_single   <= 1'b1;
                    end
                    CLS_BR: begin
                        alu_operator <= instr[13:10];
                    end
                    CLS_LI: begin
                        rf[instr[11:8]] <= instr[7:0];
                    end
                    default: ;
                endcase
            end

            // Compare results only set ALU flags; they never reach the rf.
            if (state == WB && !(ir_cls == CLS_ALU2 && ir_op == OP_CMP)) begin
                rf[ir_lo[7:4]] <= alu_bus;
            end

            if (state == BR) begin
                pc_load_reg <= alu_check_branch;
                pc_offset   <= {{(PCW-8){ir_lo[7]}}, ir_lo};
            end
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized bench for alu_sequencer. The bench
// plays the ALU (drives alu_bus and alu_check_branch) and keeps its own model of
// the register file and of the held ALU pins, updated from the instruction rules.
module tb_alu_sequencer;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_BREQ = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_LSR  = 4'h9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_value1;
    logic [7:0]  alu_value2;
    logic [3:0]  alu_operator;
    logic        alu_single;
    logic        alu_cs_in;
    logic        alu_cs_out;
    logic [7:0]  alu_bus;
    logic        alu_check_branch;
    logic        pc_load;
    logic [15:0] pc_offset;
    logic        done;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_rf [16];
    logic [7:0]  exp_v1;
    logic [7:0]  exp_v2;
    logic [3:0]  exp_op;
    logic        exp_single;
    logic [15:0] exp_pcoff;

    always #5 clk = ~clk;

    alu_sequencer #(
        .NREGS (16),
        .PCW   (16),
        .OP_CMP(OP_CMP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .alu_value1      (alu_value1),
        .alu_value2      (alu_value2),
        .alu_operator    (alu_operator),
        .alu_single      (alu_single),
        .alu_cs_in       (alu_cs_in),
        .alu_cs_out      (alu_cs_out),
        .alu_bus         (alu_bus),
        .alu_check_branch(alu_check_branch),
        .pc_load         (pc_load),
        .pc_offset       (pc_offset),
        .done            (done),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph, input logic rdy, input logic csi,
                              input logic cso, input logic dn, input logic pl);
        check({ph, ".instr_ready"},  32'(instr_ready),  32'(rdy));
        check({ph, ".cs_in"},        32'(alu_cs_in),    32'(csi));
        check({ph, ".cs_out"},       32'(alu_cs_out),   32'(cso));
        check({ph, ".done"},         32'(done),         32'(dn));
        check({ph, ".pc_load"},      32'(pc_load),      32'(pl));
        check({ph, ".value1"},       32'(alu_value1),   32'(exp_v1));
        check({ph, ".value2"},       32'(alu_value2),   32'(exp_v2));
        check({ph, ".operator"},     32'(alu_operator), 32'(exp_op));
        check({ph, ".single"},       32'(alu_single),   32'(exp_single));
        check({ph, ".pc_offset"},    32'(pc_offset),    32'(exp_pcoff));
    endtask

    task automatic check_dbg(input string tag, input logic [3:0] addr);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(m_rf[addr]));
    endtask

    task automatic check_all_rf(input string tag);
        for (int i = 0; i < 16; i++) begin
            check_dbg(tag, 4'(i));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        exp_v1     = 8'h00;
        exp_v2     = 8'h00;
        exp_op     = 4'h0;
        exp_single = 1'b0;
        exp_pcoff  = 16'h0000;
    endtask

    // Issues one instruction starting at a negedge in IDLE, plays the ALU side,
    // checks every cycle through retirement and returns at the IDLE negedge.
    task automatic run(input logic [15:0] ins, input logic [7:0] bus, input logic cb);
        logic [1:0] cls;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        cls = ins[15:14];
        op  = ins[13:10];
        rd  = ins[7:4];
        rs  = ins[3:0];
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        if (cls == 2'b00 || cls == 2'b01) begin
            exp_v1     = m_rf[rd];
            exp_v2     = (cls == 2'b01) ? 8'h00 : m_rf[rs];
            exp_op     = op;
            exp_single = (cls == 2'b01);
            check_outs("exec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            alu_bus = bus;
            @(posedge clk);
            @(negedge clk);
            check_outs("wb", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (!(cls == 2'b00 && op == OP_CMP)) m_rf[rd] = bus;
            @(posedge clk);
            @(negedge clk);
            check_outs("ret", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_dbg("ret.rf_rd", rd);
        end else if (cls == 2'b10) begin
            exp_op = op;
            check_outs("br", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            alu_check_branch = cb;
            @(posedge clk);
            @(negedge clk);
            alu_check_branch = 1'b0;
            exp_pcoff = 16'($signed(ins[7:0]));
            check_outs("br_ret", 1'b0, 1'b0, 1'b0, 1'b1, cb);
        end else begin
            m_rf[ins[11:8]] = ins[7:0];
            check_outs("li_ret", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_dbg("li.rf", ins[11:8]);
        end
        @(posedge clk);
        @(negedge clk);
        check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] mk(input logic [1:0] cls, input logic [3:0] op,
                                       input logic [3:0] rd, input logic [3:0] rs);
        return {cls, op, 2'b00, rd, rs};
    endfunction

    function automatic logic [15:0] mk_li(input logic [3:0] rd, input logic [7:0] imm);
        return {2'b11, 2'b00, rd, imm};
    endfunction

    initial begin
        logic [15:0] ins;
        rst_n            = 1'b0;
        instr            = '0;
        instr_valid      = 1'b0;
        alu_bus          = '0;
        alu_check_branch = 1'b0;
        dbg_addr         = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_rf("reset.rf");

        // Loads, ADD, CMP, LSR
        run(mk_li(4'd1, 8'h05), 8'h00, 1'b0);
        run(mk_li(4'd2, 8'h03), 8'h00, 1'b0);
        run(mk(2'b00, OP_ADD, 4'd1, 4'd2), 8'h08, 1'b0);
        run(mk_li(4'd1, 8'h05), 8'h00, 1'b0);
        run(mk(2'b00, OP_CMP, 4'd1, 4'd2), 8'h02, 1'b0);
        run(mk(2'b01, OP_LSR, 4'd2, 4'd0), 8'h01, 1'b0);
        // rd == rs
        run(mk(2'b00, OP_ADD, 4'd1, 4'd1), 8'h0A, 1'b0);
        // A single-operand op with the CMP opcode still writes back
        run(mk(2'b01, OP_CMP, 4'd3, 4'd0), 8'h77, 1'b0);

        // Branches: taken, not taken, positive offset
        run({2'b10, OP_BREQ, 2'b00, 8'hF0}, 8'h00, 1'b1);
        run({2'b10, OP_BREQ, 2'b00, 8'hF0}, 8'h00, 1'b0);
        run({2'b10, OP_BREQ, 2'b00, 8'h12}, 8'h00, 1'b1);
        // pc_load must not pulse on a following non-branch
        run(mk(2'b00, OP_ADD, 4'd4, 4'd1), 8'h33, 1'b0);

        // Reset asserted during WB of an ADD: writeback discarded
        instr       = mk(2'b00, OP_ADD, 4'd1, 4'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        alu_bus     = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        check("rst_wb.cs_out", 32'(alu_cs_out), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outs("rst_wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_all_rf("rst_wb.rf");
        @(posedge clk);
        @(negedge clk);
        check("rst_wb.no_done", 32'(done), 32'd0);

        // Back-to-back loads with instr_valid held high
        instr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("b2b.ready_idle", 32'(instr_ready), 32'd1);
            instr = mk_li(4'(k + 8), 8'(8'h40 + k));
            m_rf[k + 8] = 8'(8'h40 + k);
            @(posedge clk);
            @(negedge clk);
            check("b2b.ready_ret", 32'(instr_ready), 32'd0);
            check("b2b.done", 32'(done), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check_all_rf("b2b.rf");

        // Randomized instructions against the model
        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            if (ins[15:14] == 2'b00 && ($urandom_range(0, 3) == 0)) ins[13:10] = OP_CMP;
            run(ins, 8'($urandom), 1'($urandom));
        end
        check_all_rf("final.rf");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
